// File: rtl/ofmap_sel_pipe.sv
// ofmap_sel_pipe: per-tile source select into a 2-entry skid buffer, emitting cfg_len words.
// Optional OFMAP_RELU_EN: zero negative words on entry when the tile's cfg_relu is set.
`default_nettype none

module ofmap_sel_pipe #(
    parameter int DATA_W  = 32,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [SEL_W-1:0]          cfg_sel,
    input  logic [CNT_W-1:0]          cfg_len,
    input  logic                      cfg_relu,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [NUM_SRC-1:0]        src_valid,
    output logic [NUM_SRC-1:0]        src_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_W-1:0]          out_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [SEL_W-1:0]  r_sel;
    logic [CNT_W-1:0]  r_len;
    logic [CNT_W-1:0]  r_in_cnt;
    logic [CNT_W-1:0]  r_out_cnt;
    logic              r_relu;
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] r_head;
    logic [DATA_W-1:0] r_tail;
    logic [1:0]        r_occ;

    logic              w_sel_ok;
    logic              w_src_valid;
    logic [DATA_W-1:0] w_src_data;
    logic [DATA_W-1:0] w_in_data;
    logic              w_room;
    logic              w_acc;
    logic              w_pop;
    logic [1:0]        w_occ_nxt;
    logic [CNT_W-1:0]  w_out_cnt_nxt;
    logic              w_last;

    // An out-of-range select behaves as an always-valid source of zeros.
    always_comb begin
        w_sel_ok    = 1'b0;
        w_src_valid = 1'b1;
        w_src_data  = '0;
        src_ready   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_sel == SEL_W'(i)) begin
                w_sel_ok     = 1'b1;
                w_src_valid  = src_valid[i];
                w_src_data   = src_data[i*DATA_W +: DATA_W];
                src_ready[i] = w_room;
            end
        end
    end

`ifdef OFMAP_RELU_EN
    assign w_in_data = (r_relu && w_src_data[DATA_W-1]) ? '0 : w_src_data;
`else
    logic w_unused_relu;
    assign w_unused_relu = r_relu;
    assign w_in_data     = w_src_data;
`endif

    assign w_room        = (r_state == S_RUN) && (r_in_cnt < r_len) && (r_occ != 2'd2);
    assign w_acc         = w_room && w_src_valid;
    assign w_pop         = (r_occ != 2'd0) && out_ready;
    assign w_occ_nxt     = r_occ + {1'b0, w_acc} - {1'b0, w_pop};
    assign w_out_cnt_nxt = r_out_cnt + CNT_W'(w_pop);
    // Decide completion on next-state values so done follows the last pop by one cycle.
    assign w_last        = (w_out_cnt_nxt == r_len) && (w_occ_nxt == 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_sel     <= '0;
            r_len     <= '0;
            r_relu    <= 1'b0;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sel     <= cfg_sel;
                        r_len     <= cfg_len;
                        r_relu    <= cfg_relu;
                        r_in_cnt  <= '0;
                        r_out_cnt <= '0;
                        if (cfg_len != '0) begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_acc) begin
                        r_in_cnt <= r_in_cnt + 1'b1;
                    end
                    r_out_cnt <= w_out_cnt_nxt;
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= 2'd0;
        end else begin
            r_occ <= w_occ_nxt;
            case (r_occ)
                2'd0: begin
                    if (w_acc) r_head <= w_in_data;
                end
                2'd1: begin
                    if (w_acc && w_pop) r_head <= w_in_data;
                    else if (w_acc)     r_tail <= w_in_data;
                end
                default: begin
                    if (w_pop) r_head <= r_tail;
                end
            endcase
        end
    end

    assign out_data  = r_head;
    assign out_valid = (r_occ != 2'd0);
    assign busy      = r_busy;
    assign done      = r_done;
    assign out_cnt   = r_out_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ofmap_sel_pipe.sv
// tb_ofmap_sel_pipe: randomized tiles against a word-queue reference model of ofmap_sel_pipe.
`default_nettype none

module tb_ofmap_sel_pipe;

    localparam int DATA_W  = 32;
    localparam int NUM_SRC = 3;
    localparam int SEL_W   = 2;
    localparam int CNT_W   = 16;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      start = 1'b0;
    logic [SEL_W-1:0]          cfg_sel = '0;
    logic [CNT_W-1:0]          cfg_len = '0;
    logic                      cfg_relu = 1'b0;
    logic [NUM_SRC*DATA_W-1:0] src_data = '0;
    logic [NUM_SRC-1:0]        src_valid = '0;
    logic [NUM_SRC-1:0]        src_ready;
    logic [DATA_W-1:0]         out_data;
    logic                      out_valid;
    logic                      out_ready = 1'b0;
    logic                      busy;
    logic                      done;
    logic [CNT_W-1:0]          out_cnt;

    int n_checks = 0;
    int n_errors = 0;
    logic [DATA_W-1:0] src_words[$];

    ofmap_sel_pipe #(
        .DATA_W (DATA_W),
        .NUM_SRC(NUM_SRC),
        .SEL_W  (SEL_W),
        .CNT_W  (CNT_W)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .cfg_sel  (cfg_sel),
        .cfg_len  (cfg_len),
        .cfg_relu (cfg_relu),
        .src_data (src_data),
        .src_valid(src_valid),
        .src_ready(src_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .done     (done),
        .out_cnt  (out_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected output word for a given input word under the tile's settings.
    function automatic logic [DATA_W-1:0] model_word(input logic [DATA_W-1:0] w, input bit relu,
                                                     input bit sel_ok);
        if (!sel_ok) return '0;
`ifdef OFMAP_RELU_EN
        if (relu && ($signed(w) < 0)) return '0;
`endif
        return w;
    endfunction

    task automatic run_tile(input int sel, input int len, input bit relu, input int mode,
                            input bit poke);
        logic [DATA_W-1:0] exp_q[$];
        logic [DATA_W-1:0] held;
        bit sel_ok, stalled, exp_done, exp_rdy, acc, finished;
        int in_idx, out_idx, last_hs, first_hs, occ;
        logic [NUM_SRC-1:0] mask;
        sel_ok = (sel < NUM_SRC);
        mask = sel_ok ? NUM_SRC'(1 << sel) : '0;
        stalled = 0; finished = 0; held = '0;
        in_idx = 0; out_idx = 0; last_hs = -10; first_hs = -1;
        while (src_words.size() < len) src_words.push_back($urandom);
        for (int k = 0; k < len; k++) exp_q.push_back(model_word(src_words[k], relu, sel_ok));

        @(posedge clk); #1;
        start = 1'b1; cfg_sel = SEL_W'(sel); cfg_len = CNT_W'(len); cfg_relu = relu;
        @(posedge clk); #1;
        start = 1'b0; cfg_sel = SEL_W'($urandom); cfg_len = CNT_W'($urandom); cfg_relu = 1'($urandom);

        for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
            start = poke && (cyc == 2);
            for (int s = 0; s < NUM_SRC; s++) src_data[s*DATA_W +: DATA_W] = $urandom;
            src_valid = NUM_SRC'($urandom);
            if (sel_ok) begin
                if (in_idx < len) src_data[sel*DATA_W +: DATA_W] = src_words[in_idx];
                if (mode == 0) src_valid[sel] = 1'b1;
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase

            @(negedge clk);
            occ = in_idx - out_idx;
            exp_done = (len == 0) ? (cyc == 0) : (out_idx == len && cyc == last_hs + 1);
            exp_rdy = (len != 0) && !exp_done && (in_idx < len) && (occ < 2);
            chk_val("done", done, exp_done);
            chk_val("busy", busy, (len != 0) && !exp_done);
            chk_val("unsel_ready", src_ready & ~mask, '0);
            if (sel_ok) chk_val("src_ready", src_ready[sel], exp_rdy);
            chk_val("out_valid", out_valid, occ != 0);
            if (stalled) chk_val("stall_hold", out_data, held);
            acc = exp_rdy && (sel_ok ? src_valid[sel] : 1'b1);
            if (out_valid && out_ready) begin
                chk_val("word_count", out_idx < len, 1'b1);
                if (out_idx < len) chk_val("data", out_data, exp_q[out_idx]);
                chk_val("out_cnt_run", out_cnt, out_idx);
                if (first_hs < 0) first_hs = cyc;
                out_idx++;
                last_hs = cyc;
            end
            if (acc) in_idx++;
            stalled = out_valid && !out_ready;
            held = out_data;
            if (done) finished = 1;
            @(posedge clk); #1;
        end
        start = 1'b0;
        src_valid = '0;
        chk_val("done_seen", finished, 1'b1);
        chk_val("delivered", out_idx, len);
        chk_val("out_cnt_final", out_cnt, len);
        if (mode == 0 && len > 0) chk_val("throughput", last_hs - first_hs, len - 1);
        @(negedge clk);
        chk_val("done_pulse", done, 1'b0);
        chk_val("out_cnt_hold", out_cnt, len);
        src_words.delete();
    endtask

    initial begin
        int got;
        int r_sel, r_len, r_mode;
        #3;
        chk_val("rst_out_valid", out_valid, 1'b0);
        chk_val("rst_out_data", out_data, '0);
        chk_val("rst_src_ready", src_ready, '0);
        chk_val("rst_busy", busy, 1'b0);
        chk_val("rst_done", done, 1'b0);
        chk_val("rst_out_cnt", out_cnt, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        src_words = '{32'h10, 32'h11, 32'h12, 32'h13};
        run_tile(1, 4, 0, 0, 0);
        run_tile(2, 8, 0, 1, 1);
        run_tile(3, 5, 0, 2, 0);
        run_tile(0, 0, 0, 2, 0);
        src_words = '{32'hFFFF_FFF0, 32'h0000_0005};
        run_tile(0, 2, 1, 0, 0);

        // Reset in the middle of a six-word tile, after two words have left.
        @(posedge clk); #1;
        start = 1'b1; cfg_sel = 2'd0; cfg_len = 16'd6; cfg_relu = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        got = 0;
        for (int c = 0; c < 40 && got < 2; c++) begin
            src_valid = NUM_SRC'(1);
            src_data[0 +: DATA_W] = $urandom;
            out_ready = 1'b0;
            if (c > 0) out_ready = 1'b1;
            @(negedge clk);
            if (out_valid && out_ready) got++;
            @(posedge clk); #1;
        end
        chk_val("rst_progress", got, 2);
        #2 rst_n = 1'b0;
        #1;
        chk_val("mid_rst_out_valid", out_valid, 1'b0);
        chk_val("mid_rst_out_data", out_data, '0);
        chk_val("mid_rst_src_ready", src_ready, '0);
        chk_val("mid_rst_busy", busy, 1'b0);
        chk_val("mid_rst_done", done, 1'b0);
        chk_val("mid_rst_out_cnt", out_cnt, '0);
        src_valid = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_tile(0, 3, 0, 0, 0);

        for (int t = 0; t < 30; t++) begin
            r_sel  = $urandom_range(0, 3);
            r_len  = $urandom_range(0, 12);
            r_mode = $urandom_range(0, 2);
            run_tile(r_sel, r_len, 1'($urandom), r_mode, (r_len >= 4) && 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ofmap_sel_pipe.md
# ofmap_sel_pipe

Parametrised, handshaked successor to the combinational ofmap output mux: selects one of NUM_SRC producer streams (ReLU, accumulator, pooling, bypass, …) per tile, buffers it through a 2-entry skid buffer and emits exactly `cfg_len` words to the ofmap writer. It sits between the post-processing units and the ofmap SRAM/DMA write path. Unselected sources are back-pressured. An out-of-range select emits zeros, matching the legacy mux's default.

## Interface
Parameters:
- DATA_W, 32 (`psum_wid`), word width of every source and of the output
- NUM_SRC, 4, number of source streams; index 0 = relu, 1 = accu, 2 = pool, 3 = bypass
- SEL_W, 2, select width; must satisfy 2^SEL_W ≥ NUM_SRC
- CNT_W, 16, tile length counter width

Ports:
- clk  in  1  clock; all logic on rising edge; one clock domain
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; latches cfg_* when in IDLE
- cfg_sel  in  SEL_W  source index for the tile
- cfg_len  in  CNT_W  words to emit for the tile
- cfg_relu  in  1  per-tile ReLU request (used only with OFMAP_RELU_EN)
- src_data  in  NUM_SRC*DATA_W  source words; source i occupies bits [i*DATA_W +: DATA_W]
- src_valid  in  NUM_SRC  per-source valid
- src_ready  out  NUM_SRC  per-source ready
- out_data  out  DATA_W  registered output word
- out_valid  out  1  output valid
- out_ready  in  1  downstream ready
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at tile completion
- out_cnt  out  CNT_W  words emitted in the current or last tile

## Operation
- FSM states:
  - IDLE: start → latch sel, len and relu; clear in_cnt and out_cnt. Go to RUN if len ≠ 0, otherwise to DONE.
  - RUN: stay until out_cnt == len and the skid buffer is empty, then go to DONE.
  - DONE: assert done for one cycle, then return to IDLE.
- start while not in IDLE is ignored; cfg_* are sampled only on an accepted start.
- Valid select (sel < NUM_SRC):
  - src_ready[sel] = RUN && in_cnt < len && skid buffer not full.
  - All other src_ready bits are 0.
  - An input is accepted when src_valid[sel] && src_ready[sel]; each acceptance increments in_cnt.
- Invalid select (sel ≥ NUM_SRC):
  - No source is ever readied.
  - The block internally generates len zero words with the same output handshake.
- Output:
  - The skid buffer head drives out_data/out_valid.
  - Each out_valid && out_ready increments out_cnt.
- Skid buffer:
  - Two entries. An accept and a pop in the same cycle keep the occupancy unchanged.
  - An accept when full is impossible, because ready is deasserted.
- Counters wrap never: in_cnt and out_cnt saturate at len by construction. out_cnt holds its value after DONE until the next start.

## Timing
- Reset values: out_valid=0, out_data=0, src_ready=0, busy=0, done=0, out_cnt=0, FSM=IDLE, buffer empty.
- Latency:
  - start → busy: 1 cycle.
  - Source accept → out_valid: 1 cycle when the buffer is empty.
  - Sustained throughput is 1 word/cycle with out_ready held high.
- Last output handshake → done: 1 cycle. done → IDLE: 1 cycle. The earliest next start is accepted in the cycle after done.
- When out_valid=1 and out_ready=0, out_data is held stable.
- When len=0, done pulses 1 cycle after start and no src_ready is ever asserted.
- rst_n asserted mid-tile clears all state immediately. Buffered words are discarded and not emitted.

## Configuration
- OFMAP_RELU_EN defined: when the latched cfg_relu=1, words with MSB=1 (negative, signed) are replaced by 0 as they enter the skid buffer. Positive words and zero-fill words pass unchanged.
- OFMAP_RELU_EN undefined: cfg_relu is ignored and data passes bit-exact. The port remains present.

## Test plan
- sel=1, len=4, accu source sends 0x10–0x13, out_ready=1 → out_data 0x10..0x13 on 4 consecutive cycles; done 1 cycle after the last word; out_cnt=4; src_ready[0,2,3] never high.
- sel=2, len=8, out_ready toggled 1/0 each cycle → all 8 words delivered in order with none dropped or duplicated; out_data stable during stalls; src_ready[2] low whenever the buffer is full.
- sel=3 with NUM_SRC=3, len=5 → five 0x0 words; all src_ready stay 0; done pulses.
- len=0 start → done 1 cycle later; out_valid never asserts. A start pulse while busy → ignored and the tile unaffected.
- OFMAP_RELU_EN, cfg_relu=1, source 0 sends 0xFFFFFFF0, 0x00000005 → outputs 0x0, 0x5. Without the macro → 0xFFFFFFF0, 0x5.
- rst_n low after 2 of 6 words → all outputs at reset values immediately; a fresh start with len=3 completes normally.
